store_queue: RTL

In-order committed-store buffer sitting between the reorder buffer commit stage and data memory. It accepts one retired store per cycle from commit, holds it in a FIFO, and drains entries to data memory over a req/ack handshake. It also gives load issue store-to-load forwarding from its youngest matching entry. Entries are already architecturally committed, so the block has no flush input: every accepted store is eventually written.

---
 rtl/store_queue_if.sv | 37 +++
 rtl/store_queue.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/store_queue_if.sv
// store_queue_if: bus bundle for the committed-store buffer.
//   commit_*  : retired stores from the commit stage (valid/ready)
//   mem_*     : write port to data memory (req/ack, req side registered)
//   ld_*      : store-to-load forwarding lookup
//   empty/count : occupancy status
// slave modport is the queue itself, master modport is its environment.
interface store_queue_if #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              commit_valid;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic              commit_ready;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_hit;
  logic [DATA_W-1:0] ld_data;
  logic              empty;
  logic [CNT_W-1:0]  count;

  modport slave (
    input  commit_valid, commit_addr, commit_data, mem_ack, ld_addr,
    output commit_ready, mem_req, mem_addr, mem_wdata, ld_hit, ld_data, empty, count
  );

  modport master (
    output commit_valid, commit_addr, commit_data, mem_ack, ld_addr,
    input  commit_ready, mem_req, mem_addr, mem_wdata, ld_hit, ld_data, empty, count
  );
endinterface

// File: rtl/store_queue.sv
// store_queue: in-order buffer of committed stores between commit and data
// memory. Accepts one store per cycle, drains oldest-first over a registered
// req/ack write port, and forwards data from the youngest matching entry to
// load lookups.
// Ports:
//   CLOCK_50 : clock, all state on rising edge
//   RSTN_N   : asynchronous active-low reset
//   bus      : store_queue_if.slave (commit, memory, forwarding, status)
module store_queue #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 10,
  parameter int DATA_W = 32
) (
  input  logic           CLOCK_50,
  input  logic           RSTN_N,
  store_queue_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_REQ  = 1'b1
  } state_t;

  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic [DATA_W-1:0] r_data [DEPTH];

  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  logic              r_mem_req;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  state_t            w_state_nxt;
  logic              w_req_nxt;
  logic [ADDR_W-1:0] w_addr_nxt;
  logic [DATA_W-1:0] w_wdata_nxt;

  logic              w_ready;
  logic              w_push;
  logic              w_pop;
  logic [PTR_W-1:0]  w_head_inc;
  logic [PTR_W-1:0]  w_fwd_idx;
  logic              w_fwd_match;
  logic              w_ld_hit;
  logic [DATA_W-1:0] w_ld_data;

  // Ready depends on the current count only, so a pop at a full edge does not admit a push.
  assign w_ready    = (r_count != CNT_W'(DEPTH));
  assign w_push     = bus.commit_valid && w_ready;
  assign w_pop      = (r_state == ST_REQ) && bus.mem_ack;
  assign w_head_inc = r_head + PTR_W'(1);

  // Entry storage write; contents are not reset, occupancy is tracked by count.
  always_ff @(posedge CLOCK_50) begin
    if (w_push) begin
      r_addr[r_tail] <= bus.commit_addr;
      r_data[r_tail] <= bus.commit_data;
    end
  end

  // Head/tail pointers and occupancy count.
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PTR_W'(1);
      end
      if (w_pop) begin
        r_head <= w_head_inc;
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  // Drain FSM next-state and registered memory-port values.
  always_comb begin
    w_state_nxt = r_state;
    w_req_nxt   = r_mem_req;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    case (r_state)
      ST_IDLE: begin
        // A push at this same edge is not yet in storage; it is picked up next edge.
        if (r_count != '0) begin
          w_state_nxt = ST_REQ;
          w_req_nxt   = 1'b1;
          w_addr_nxt  = r_addr[r_head];
          w_wdata_nxt = r_data[r_head];
        end else begin
          w_state_nxt = ST_IDLE;
          w_req_nxt   = 1'b0;
        end
      end
      ST_REQ: begin
        if (w_pop) begin
          if (r_count > CNT_W'(1)) begin
            w_addr_nxt  = r_addr[w_head_inc];
            w_wdata_nxt = r_data[w_head_inc];
          end else if (w_push) begin
            // Queue would empty, but the store arriving now becomes the next write.
            w_addr_nxt  = bus.commit_addr;
            w_wdata_nxt = bus.commit_data;
          end else begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
          end
        end else begin
          w_state_nxt = ST_REQ;
          w_req_nxt   = 1'b1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_req_nxt   = 1'b0;
      end
    endcase
  end

  // Drain FSM state and memory-port registers.
  always_ff @(posedge CLOCK_50 or negedge RSTN_N) begin
    if (!RSTN_N) begin
      r_state     <= ST_IDLE;
      r_mem_req   <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  // Forwarding: walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    w_ld_hit    = 1'b0;
    w_ld_data   = '0;
    w_fwd_idx   = '0;
    w_fwd_match = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w_fwd_idx   = r_head + PTR_W'(i);
      w_fwd_match = (CNT_W'(i) < r_count) && (r_addr[w_fwd_idx] == bus.ld_addr);
      w_ld_hit    = w_fwd_match ? 1'b1 : w_ld_hit;
      w_ld_data   = w_fwd_match ? r_data[w_fwd_idx] : w_ld_data;
    end
  end

  assign bus.commit_ready = w_ready;
  assign bus.mem_req      = r_mem_req;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.mem_wdata    = r_mem_wdata;
  assign bus.ld_hit       = w_ld_hit;
  assign bus.ld_data      = w_ld_data;
  assign bus.empty        = (r_count == '0);
  assign bus.count        = r_count;
endmodule
